mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one single-port unified memory between the fetch path (PCim-driven instruction reads) and the MEM-stage data path (loads and stores).
- Arbitrates between the two, holds the memory request stable until the memory acknowledges, and returns read data with a one-cycle valid pulse.
- Drives the stall inputs of the pipeline.
- A watchdog converts a hung memory access into an error response.

Parameters:
- ADDR_W, 12: fetch/data address width (matches PC width).
- DATA_W, 32: data width.
- TIMEOUT_CYC, 15: cycles without mem_ack before abort; minimum 2.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- if_req  in  1  fetch read request; held until if_valid
- if_addr  in  ADDR_W  fetch byte address
- if_kill  in  1  branch flush: discard the outstanding/pending fetch
- if_valid  out  1  one-cycle pulse, if_rdata valid
- if_rdata  out  DATA_W  fetched instruction
- if_stall  out  1  fetch must hold (feeds pcwrite/fdwrite)
- dm_req  in  1  data request; held until dm_done
- dm_we  in  1  1 = store, 0 = load
- dm_addr  in  ADDR_W  data byte address
- dm_wdata  in  DATA_W  store data
- dm_len  in  2  00 byte, 01 half, 10 word
- dm_done  out  1  one-cycle pulse: access complete, dm_rdata valid for loads
- dm_rdata  out  DATA_W  load data, raw and unextended
- dm_stall  out  1  MEM stage and everything older must hold
- mem_en  out  1  memory request
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_len  out  2  access size
- mem_ack  in  1  one-cycle memory completion; mem_rdata valid
- mem_rdata  in  DATA_W  memory read data
- err  out  1  sticky timeout flag; cleared only by rst

Behaviour:
- States: IDLE, BUSY_I, BUSY_D.
- Reset values: state = IDLE, last_grant = DATA. All outputs 0, including mem_* and both rdata buses.
- In IDLE, the eligible requests are if_req & ~if_kill and dm_req. The requester that pulsed valid/done in this cycle is masked, so a held req is not re-granted.
  - Only one eligible: grant it.
  - Both eligible: grant the one not equal to last_grant. After reset, fetch therefore wins the first tie.
  - At the edge, latch address, we, wdata and len into the mem_* registers; set mem_en = 1; go to BUSY_I or BUSY_D; update last_grant.
  - A fetch always drives mem_we = 0 and mem_len = 10.
- BUSY_x:
  - mem_* are held constant until mem_ack.
  - On mem_ack: capture mem_rdata into x_rdata, pulse if_valid or dm_done in the next cycle, clear mem_en, return to IDLE.
  - Minimum latency is 3 cycles, measured from req seen in IDLE to the valid/done pulse (mem_ack 1 cycle after mem_en).
  - x_rdata holds until the next capture.
- if_kill:
  - In BUSY_I: the access completes normally, but if_valid is suppressed and if_rdata is not updated.
  - In IDLE: a pending if_req is not granted that cycle.
- Watchdog:
  - A counter clears on grant and increments each BUSY cycle.
  - Reaching TIMEOUT_CYC without mem_ack: set err, drop mem_en, return to IDLE, and pulse valid/done with rdata = 0.
- if_stall = if_req & ~if_valid. dm_stall = dm_req & ~dm_done. Both are combinational.
- mem_ack while in IDLE (late or spurious) is ignored.
- A rst asserted mid-access aborts it: mem_en = 0 in the cycle after rst; no valid or done pulse.
- Back-to-back: after a done pulse, the other pending requester is granted in that same IDLE cycle, giving a zero-bubble alternation.

Decomposition:
- Shared package mem_arb_pkg holds:
  - the state enum arb_state_t {IDLE, BUSY_I, BUSY_D};
  - the requester enum req_id_t {REQ_IF, REQ_DM};
  - the len constants LEN_B, LEN_H, LEN_W.
- One sub-module, arb_watchdog: a counter with clear/enable inputs and a timeout output.

Test Plan:
- Single fetch, if_addr = 0x010, mem_ack 1 cycle after mem_en with mem_rdata = 0x00500093 -> mem_en seen 1 cycle after req; if_valid pulses 3 cycles after req with if_rdata = 0x00500093; if_stall = 1 until then.
- First cycle after reset, if_req and dm_req rise together, dm store of 0xDEADBEEF to 0x020 with len 10 -> fetch granted first; then the store gets mem_we = 1 and mem_addr = 0x020, starting in the cycle the if_valid pulse occurs; dm_stall stays high until dm_done.
- Both requests held continuously for 8 accesses -> grants alternate IF, DM, IF, DM, ...; neither stall ever exceeds 2 back-to-back accesses.
- if_kill pulsed while in BUSY_I -> the access completes, no if_valid pulse, if_rdata unchanged; the next dm_req is granted immediately.
- mem_ack never asserted for a load at 0x044 -> after 15 BUSY cycles: err = 1, dm_done pulses with dm_rdata = 0, mem_en = 0; err remains 1 until rst.
- rst asserted in BUSY_D, then a stray mem_ack 2 cycles later -> all outputs 0 after reset, state IDLE, stray ack produces no pulse.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified-memory port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} arb_state_t;

  typedef enum logic {REQ_IF, REQ_DM} req_id_t;

  localparam logic [1:0] LEN_B = 2'b00;
  localparam logic [1:0] LEN_H = 2'b01;
  localparam logic [1:0] LEN_W = 2'b10;

endpackage

// File: rtl/arb_watchdog.sv
// Busy-cycle counter: raises timeout on the TIMEOUT_CYC-th busy cycle since the last clear.
module arb_watchdog #(
  parameter int unsigned TIMEOUT_CYC = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic timeout
);

  localparam int unsigned CW = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en && !timeout) begin
      cnt <= cnt + CW'(1);
    end
  end

  assign timeout = en && (cnt == CW'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port memory between instruction fetch and MEM-stage
// loads/stores, with a watchdog that turns a hung access into an error response.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W      = 12,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned TIMEOUT_CYC = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_kill,
  output logic              if_valid,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_stall,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  input  logic [1:0]        dm_len,
  output logic              dm_done,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_stall,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [1:0]        mem_len,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              err
);

  arb_state_t state, state_d;
  req_id_t    last_grant;
  logic       killed;
  logic       elig_if, elig_dm, grant_if, grant_dm;
  logic       busy, finish, fetch_ok, timeout;
  logic [DATA_W-1:0] cap_data;

  arb_watchdog #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_wdog (
    .clk     (clk),
    .rst     (rst),
    .clr     (grant_if | grant_dm),
    .en      (busy),
    .timeout (timeout)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  always_comb begin
    state_d = state;
    unique case (state)
      IDLE: begin
        if (grant_if)      state_d = BUSY_I;
        else if (grant_dm) state_d = BUSY_D;
      end
      BUSY_I, BUSY_D: if (finish) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The requester pulsing valid/done this cycle is masked so its held req is not re-granted.
  always_comb begin
    elig_if  = if_req & ~if_kill & ~if_valid;
    elig_dm  = dm_req & ~dm_done;
    grant_if = 1'b0;
    grant_dm = 1'b0;
    if (state == IDLE) begin
      if (elig_if && elig_dm) begin
        grant_if = (last_grant == REQ_DM);
        grant_dm = ~grant_if;
      end else begin
        grant_if = elig_if;
        grant_dm = elig_dm;
      end
    end
    busy     = (state != IDLE);
    finish   = busy & (mem_ack | timeout);
    fetch_ok = (state == BUSY_I) & ~killed & ~if_kill;
    cap_data = mem_ack ? mem_rdata : '0;
    if_stall = if_req & ~if_valid;
    dm_stall = dm_req & ~dm_done;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= REQ_DM;
      killed     <= 1'b0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_len    <= '0;
      if_valid   <= 1'b0;
      dm_done    <= 1'b0;
      if_rdata   <= '0;
      dm_rdata   <= '0;
      err        <= 1'b0;
    end else begin
      if_valid <= 1'b0;
      dm_done  <= 1'b0;
      if (grant_if || grant_dm) begin
        mem_en     <= 1'b1;
        mem_we     <= grant_dm & dm_we;
        mem_addr   <= grant_if ? if_addr : dm_addr;
        mem_wdata  <= grant_if ? '0 : dm_wdata;
        mem_len    <= grant_if ? LEN_W : dm_len;
        last_grant <= grant_if ? REQ_IF : REQ_DM;
        killed     <= 1'b0;
      end else if (finish) begin
        // A timeout completes like an ack carrying zero data, plus the sticky error.
        mem_en <= 1'b0;
        if (!mem_ack) err <= 1'b1;
        if (state == BUSY_D) begin
          dm_done  <= 1'b1;
          dm_rdata <= cap_data;
        end else if (fetch_ok) begin
          if_valid <= 1'b1;
          if_rdata <= cap_data;
        end
      end else if ((state == BUSY_I) && if_kill) begin
        killed <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed vectors, corner sequences, random traffic.
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_req = 1'b0, if_kill = 1'b0, if_valid, if_stall;
  logic [11:0] if_addr = '0;
  logic [31:0] if_rdata;
  logic        dm_req = 1'b0, dm_we = 1'b0, dm_done, dm_stall;
  logic [11:0] dm_addr = '0;
  logic [31:0] dm_wdata = '0, dm_rdata;
  logic [1:0]  dm_len = '0;
  logic        mem_en, mem_we, mem_ack = 1'b0, err;
  logic [11:0] mem_addr;
  logic [31:0] mem_wdata, mem_rdata = '0;
  logic [1:0]  mem_len;

  mem_port_arbiter #(.ADDR_W(12), .DATA_W(32), .TIMEOUT_CYC(15)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_kill(if_kill),
    .if_valid(if_valid), .if_rdata(if_rdata), .if_stall(if_stall),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_len(dm_len), .dm_done(dm_done), .dm_rdata(dm_rdata), .dm_stall(dm_stall),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_len(mem_len), .mem_ack(mem_ack), .mem_rdata(mem_rdata), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_dm;
    bit          we;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic [1:0]  len;
    int          dly;
    logic [31:0] rd;
    int          exp_lat;
    logic [1:0]  exp_len;
  } vec_t;

  int          n_vec = 0;
  int          n_bad = 0;
  logic [31:0] last_if = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk1({tag, "_mem_en"}, mem_en, 1'b0);
    chk1({tag, "_mem_we"}, mem_we, 1'b0);
    chk({tag, "_mem_addr"}, 32'(mem_addr), 32'h0);
    chk({tag, "_mem_wdata"}, mem_wdata, 32'h0);
    chk({tag, "_mem_len"}, 32'(mem_len), 32'h0);
    chk1({tag, "_if_valid"}, if_valid, 1'b0);
    chk1({tag, "_dm_done"}, dm_done, 1'b0);
    chk({tag, "_if_rdata"}, if_rdata, 32'h0);
    chk({tag, "_dm_rdata"}, dm_rdata, 32'h0);
    chk1({tag, "_err"}, err, 1'b0);
  endtask

  task automatic run_vec(input vec_t v);
    int c = 0, age = -1, lat = -1;
    logic [31:0] got = '0;
    bit stall_ok = 1'b1;
    if (v.is_dm) begin
      dm_req = 1'b1; dm_we = v.we; dm_addr = v.addr; dm_wdata = v.wdata; dm_len = v.len;
    end else begin
      if_req = 1'b1; if_addr = v.addr;
    end
    #1;
    chk1("vec_stall_on", v.is_dm ? dm_stall : if_stall, 1'b1);
    while (c < 40 && lat < 0) begin
      step();
      c++;
      mem_ack = 1'b0;
      if (v.is_dm ? dm_done : if_valid) begin
        lat = c;
        got = v.is_dm ? dm_rdata : if_rdata;
        chk1("vec_stall_off", v.is_dm ? dm_stall : if_stall, 1'b0);
      end else begin
        if (!(v.is_dm ? dm_stall : if_stall)) stall_ok = 1'b0;
        if (mem_en) begin
          age++;
          if (age == 0) begin
            chk("vec_mem_addr", 32'(mem_addr), 32'(v.addr));
            chk1("vec_mem_we", mem_we, v.is_dm & v.we);
            chk("vec_mem_len", 32'(mem_len), 32'(v.exp_len));
            if (v.is_dm && v.we) chk("vec_mem_wdata", mem_wdata, v.wdata);
          end
          if (age == v.dly) begin
            mem_ack = 1'b1;
            mem_rdata = v.rd;
          end
        end
      end
    end
    chk("vec_latency", lat, v.exp_lat);
    chk("vec_rdata", got, v.rd);
    chk1("vec_stall_hold", stall_ok, 1'b1);
    if_req = 1'b0; dm_req = 1'b0; dm_we = 1'b0; mem_ack = 1'b0;
    step();
    chk1("vec_no_regrant", mem_en, 1'b0);
    if (!v.is_dm) last_if = v.rd;
  endtask

  // Random-phase model state
  logic [31:0] mm [64];
  int          own, last_own, age, dly;
  bit          killed, exp_ifv, exp_dmd, nifv, ndmd, eif, edm;
  logic [11:0] g_addr;
  logic        g_we;
  logic [31:0] g_wd, exp_ifr, exp_dmr;
  logic [1:0]  g_len;

  initial begin
    vec_t vt [5];
    vt[0] = '{is_dm:0, we:0, addr:12'h010, wdata:32'h0,  len:LEN_W, dly:1, rd:32'h00500093, exp_lat:3, exp_len:LEN_W};
    vt[1] = '{is_dm:1, we:0, addr:12'h044, wdata:32'h0,  len:LEN_W, dly:1, rd:32'h12345678, exp_lat:3, exp_len:LEN_W};
    vt[2] = '{is_dm:1, we:1, addr:12'h023, wdata:32'hA5, len:LEN_B, dly:3, rd:32'h00000000, exp_lat:5, exp_len:LEN_B};
    vt[3] = '{is_dm:1, we:0, addr:12'h102, wdata:32'h0,  len:LEN_H, dly:2, rd:32'hFFFF8001, exp_lat:4, exp_len:LEN_H};
    vt[4] = '{is_dm:0, we:0, addr:12'hFFC, wdata:32'h0,  len:LEN_B, dly:6, rd:32'hCAFEF00D, exp_lat:8, exp_len:LEN_W};

    repeat (3) step();
    rst = 1'b0;
    step();
    chk_zero("reset");

    // Simultaneous requests right after reset: fetch wins, then the store.
    if_req = 1'b1; if_addr = 12'h000;
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 12'h020; dm_wdata = 32'hDEADBEEF; dm_len = LEN_W;
    step();
    chk1("tie_mem_en", mem_en, 1'b1);
    chk1("tie_first_we", mem_we, 1'b0);
    chk("tie_first_addr", 32'(mem_addr), 32'h0);
    chk("tie_first_len", 32'(mem_len), 32'(LEN_W));
    step();
    mem_ack = 1'b1; mem_rdata = 32'h00000013;
    step();
    mem_ack = 1'b0;
    chk1("tie_if_valid", if_valid, 1'b1);
    chk("tie_if_rdata", if_rdata, 32'h00000013);
    chk1("tie_dm_stall_a", dm_stall, 1'b1);
    if_req = 1'b0;
    step();
    chk1("tie_st_en", mem_en, 1'b1);
    chk1("tie_st_we", mem_we, 1'b1);
    chk("tie_st_addr", 32'(mem_addr), 32'h020);
    chk("tie_st_wdata", mem_wdata, 32'hDEADBEEF);
    chk1("tie_dm_stall_b", dm_stall, 1'b1);
    step();
    mem_ack = 1'b1; mem_rdata = 32'h0;
    step();
    mem_ack = 1'b0;
    chk1("tie_dm_done", dm_done, 1'b1);
    chk1("tie_dm_stall_off", dm_stall, 1'b0);
    dm_req = 1'b0; dm_we = 1'b0;
    step();

    for (int i = 0; i < 5; i++) run_vec(vt[i]);

    // Both requesters held for 8 accesses: strict alternation, no bubbles.
    begin
      int c = 0, done = 0, grants = 0, a = -1, prev = -1, first = -1, cur = 0;
      int run_if = 0, run_dm = 0, max_if = 0, max_dm = 0;
      bit alt_ok = 1'b1;
      logic [31:0] ack_val = '0;
      if_req = 1'b1; if_addr = 12'h100;
      dm_req = 1'b1; dm_we = 1'b0; dm_addr = 12'h200; dm_len = LEN_W;
      while (c < 100 && done < 8) begin
        step();
        c++;
        mem_ack = 1'b0;
        run_if = if_stall ? run_if + 1 : 0;
        run_dm = dm_stall ? run_dm + 1 : 0;
        if (run_if > max_if) max_if = run_if;
        if (run_dm > max_dm) max_dm = run_dm;
        if (if_valid || dm_done) begin
          done++;
          chk("alt_rdata", if_valid ? if_rdata : dm_rdata, ack_val);
        end
        if (mem_en) begin
          a++;
          if (a == 0) begin
            cur = (mem_addr == 12'h100) ? 0 : 1;
            grants++;
            if (first < 0) first = cur;
            if (prev == cur) alt_ok = 1'b0;
            prev = cur;
          end else if (a == 1) begin
            mem_ack = 1'b1;
            ack_val = 32'h1000 + 32'(grants);
            mem_rdata = ack_val;
            if (cur == 0) last_if = ack_val;
          end
        end else begin
          a = -1;
        end
        if (done == 8) begin
          if_req = 1'b0; dm_req = 1'b0;
        end
      end
      chk("alt_grants", grants, 8);
      chk("alt_cycles", c, 24);
      chk("alt_first_dm", first, 1);
      chk1("alt_alternates", alt_ok, 1'b1);
      chk1("alt_if_stall_bound", max_if <= 6, 1'b1);
      chk1("alt_dm_stall_bound", max_dm <= 6, 1'b1);
      step();
      chk1("alt_quiet", mem_en, 1'b0);
    end

    // Fetch flushed while busy: completes silently, data path goes next.
    if_req = 1'b1; if_addr = 12'h300;
    step();
    chk1("kill_en", mem_en, 1'b1);
    chk("kill_addr", 32'(mem_addr), 32'h300);
    if_kill = 1'b1;
    step();
    if_kill = 1'b0; if_req = 1'b0;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 12'h044; dm_len = LEN_W;
    mem_ack = 1'b1; mem_rdata = 32'h11111111;
    step();
    mem_ack = 1'b0;
    chk1("kill_no_valid", if_valid, 1'b0);
    chk("kill_rdata_kept", if_rdata, last_if);
    chk1("kill_en_drop", mem_en, 1'b0);
    step();
    chk1("kill_dm_en", mem_en, 1'b1);
    chk("kill_dm_addr", 32'(mem_addr), 32'h044);
    step();
    mem_ack = 1'b1; mem_rdata = 32'h0BADF00D;
    step();
    mem_ack = 1'b0;
    chk1("kill_dm_done", dm_done, 1'b1);
    chk("kill_dm_rdata", dm_rdata, 32'h0BADF00D);
    dm_req = 1'b0;
    step();

    // Load with no ack: watchdog aborts after 15 busy cycles.
    begin
      bit en_ok = 1'b1;
      dm_req = 1'b1; dm_we = 1'b0; dm_addr = 12'h044; dm_len = LEN_W;
      for (int i = 1; i <= 15; i++) begin
        step();
        if (!mem_en || dm_done) en_ok = 1'b0;
      end
      chk1("to_en_held", en_ok, 1'b1);
      chk1("to_err_before", err, 1'b0);
      step();
      chk1("to_dm_done", dm_done, 1'b1);
      chk("to_dm_rdata", dm_rdata, 32'h0);
      chk1("to_mem_en", mem_en, 1'b0);
      chk1("to_err", err, 1'b1);
      dm_req = 1'b0;
      step();
      mem_ack = 1'b1; mem_rdata = 32'h77777777;
      step();
      mem_ack = 1'b0;
      chk1("to_spurious_ack", dm_done | if_valid, 1'b0);
      repeat (3) step();
      chk1("to_err_sticky", err, 1'b1);
    end

    // Reset in the middle of a data access, then a stray ack.
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 12'h080; dm_len = LEN_W;
    step();
    chk1("rst_busy_en", mem_en, 1'b1);
    rst = 1'b1;
    step();
    rst = 1'b0; dm_req = 1'b0;
    chk_zero("rst_mid");
    step();
    mem_ack = 1'b1; mem_rdata = 32'h55AA55AA;
    step();
    mem_ack = 1'b0;
    chk1("rst_stray_done", dm_done | if_valid, 1'b0);
    chk1("rst_stray_en", mem_en, 1'b0);

    // Random traffic against a transaction-level model of the memory port.
    for (int i = 0; i < 64; i++) mm[i] = $urandom;
    own = 0; last_own = 2; age = 0; dly = 1; killed = 1'b0;
    exp_ifv = 1'b0; exp_dmd = 1'b0; exp_ifr = '0; exp_dmr = '0;
    g_addr = '0; g_we = 1'b0; g_wd = '0; g_len = '0;
    for (int cyc = 0; cyc < 800; cyc++) begin
      step();
      chk1("rnd_if_valid", if_valid, exp_ifv);
      chk1("rnd_dm_done", dm_done, exp_dmd);
      chk("rnd_if_rdata", if_rdata, exp_ifr);
      chk("rnd_dm_rdata", dm_rdata, exp_dmr);
      chk1("rnd_mem_en", mem_en, own != 0);
      if (own != 0) begin
        chk("rnd_mem_addr", 32'(mem_addr), 32'(g_addr));
        chk1("rnd_mem_we", mem_we, g_we);
        chk("rnd_mem_len", 32'(mem_len), 32'(g_len));
        if (g_we) chk("rnd_mem_wdata", mem_wdata, g_wd);
      end
      mem_ack = 1'b0; if_kill = 1'b0;
      mem_rdata = $urandom;
      if (exp_ifv || !if_req) begin
        if_req = ($urandom_range(0, 2) != 0);
        if_addr = {4'h0, 6'($urandom_range(0, 63)), 2'b00};
      end else if ($urandom_range(0, 15) == 0) begin
        if_kill = 1'b1;
        if_addr = {4'h0, 6'($urandom_range(0, 63)), 2'b00};
      end
      if (exp_dmd || !dm_req) begin
        dm_req = ($urandom_range(0, 2) != 0);
        dm_we = 1'($urandom_range(0, 1));
        dm_addr = 12'($urandom_range(0, 4095));
        dm_wdata = $urandom;
        dm_len = 2'($urandom_range(0, 2));
      end
      if (own != 0 && age >= dly) begin
        mem_ack = 1'b1;
        if (!(own == 2 && g_we)) mem_rdata = mm[g_addr[7:2]];
      end else if (own == 0 && $urandom_range(0, 19) == 0) begin
        mem_ack = 1'b1;
      end
      #1;
      chk1("rnd_if_stall", if_stall, if_req & ~exp_ifv);
      chk1("rnd_dm_stall", dm_stall, dm_req & ~exp_dmd);
      nifv = 1'b0; ndmd = 1'b0;
      if (own != 0) begin
        if (own == 1 && if_kill) killed = 1'b1;
        if (mem_ack) begin
          if (own == 1) begin
            if (!killed) begin nifv = 1'b1; exp_ifr = mem_rdata; end
          end else begin
            ndmd = 1'b1; exp_dmr = mem_rdata;
            if (g_we) mm[g_addr[7:2]] = g_wd;
          end
          own = 0;
        end else begin
          age++;
        end
      end else begin
        eif = if_req && !if_kill && !exp_ifv;
        edm = dm_req && !exp_dmd;
        if (eif || edm) begin
          if (eif && edm) own = (last_own == 1) ? 2 : 1;
          else            own = eif ? 1 : 2;
          last_own = own;
          if (own == 1) begin
            g_addr = if_addr; g_we = 1'b0; g_wd = '0; g_len = LEN_W;
          end else begin
            g_addr = dm_addr; g_we = dm_we; g_wd = dm_wdata; g_len = dm_len;
          end
          age = 0; killed = 1'b0;
          dly = $urandom_range(1, 4);
        end
      end
      exp_ifv = nifv; exp_dmd = ndmd;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
